// File: rtl/rvfi_trace_serializer.sv
// RVFI commit-port trace serializer.
// Packs each cycle's commit and trap events, in port order, into a FIFO that feeds a
// valid/ready trace stream. Also keeps retire/trap/drop statistics and detects halt and
// commit-stall timeouts.

package riscv;
  localparam int unsigned XLEN = 64;
  localparam int unsigned VLEN = 39;
endpackage

package rvfi_pkg;
  typedef struct packed {
    logic                   valid;
    logic [63:0]            order;
    logic [31:0]            insn;
    logic                   trap;
    logic [riscv::XLEN-1:0] cause;
    logic [1:0]             mode;
    logic [4:0]             rd_addr;
    logic [riscv::XLEN-1:0] rd_wdata;
    logic [riscv::VLEN-1:0] pc_rdata;
  } rvfi_instr_t;
endpackage

module rvfi_trace_serializer #(
  parameter int unsigned  NR_COMMIT_PORTS = 2,
  parameter int unsigned  FIFO_DEPTH      = 8,
  parameter int unsigned  CYCLE_W         = 32,
  parameter int unsigned  WATCHDOG_CYCLES = 100000,
  parameter logic [31:0]  HALT_INSN       = 32'h00000073,
  localparam int unsigned PortW           = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        enable_i,
  input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
  output logic                                        trc_valid_o,
  input  logic                                        trc_ready_i,
  output logic [63:0]                                 trc_pc_o,
  output logic [31:0]                                 trc_insn_o,
  output logic [4:0]                                  trc_rd_o,
  output logic [riscv::XLEN-1:0]                      trc_rd_wdata_o,
  output logic                                        trc_fp_o,
  output logic [1:0]                                  trc_mode_o,
  output logic                                        trc_trap_o,
  output logic [PortW-1:0]                            trc_port_o,
  output logic [CYCLE_W-1:0]                          trc_cycle_o,
  output logic [63:0]                                 retired_cnt_o,
  output logic [31:0]                                 trap_cnt_o,
  output logic [31:0]                                 drop_cnt_o,
  output logic                                        halt_o,
  output logic                                        watchdog_o
);

  localparam int unsigned     PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned     CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     EvW     = $clog2(NR_COMMIT_PORTS + 1);
  localparam logic [PtrW-1:0] PtrMask = PtrW'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [63:0]            pc;
    logic [31:0]            insn;
    logic [4:0]             rd;
    logic [riscv::XLEN-1:0] wdata;
    logic                   fp;
    logic [1:0]             mode;
    logic                   trap;
    logic [PortW-1:0]       port;
    logic [CYCLE_W-1:0]     cycle;
  } entry_t;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  // Destination-is-FP decode covering loads, fused ops, OP-FP and compressed FP loads.
  function automatic logic is_fp(input logic [31:0] insn);
    logic fp;
    fp = 1'b0;
    case (insn[6:0])
      7'b1001111, 7'b1001011, 7'b1000111, 7'b1000011, 7'b0000111: fp = 1'b1;
      // Compares, classify and moves to integer write an integer register.
      7'b1010011: fp = !(insn[31:26] inside {6'b111000, 6'b101000, 6'b110000});
      default:    fp = 1'b0;
    endcase
    if (!insn[0] && (insn[15:13] == ((riscv::XLEN == 64) ? 3'b001 : 3'b011))) begin
      fp = 1'b1;
    end
    return fp;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [EvW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  state_e             state_q, state_d;
  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [63:0]        retired_q, retired_d;
  logic [31:0]        trap_q, trap_d, drop_q, drop_d;
  logic [31:0]        wd_q, wd_d;
  logic               halted_q, halted_d;
  logic               halt_q, halt_d;
  logic               wdog_q, wdog_d;

  entry_t                 ent [NR_COMMIT_PORTS];
  logic [EvW-1:0]         off [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] ev;
  logic [EvW-1:0]         n_ev, n_ret, n_trap;
  logic                   capture, halt_seen, any_commit;
  logic                   pop, accept, fifo_nempty;
  logic [CntW-1:0]        free;
  logic [31:0]            wd_inc;
  entry_t                 head;
  logic                   unused_rvfi;

  assign capture     = (state_q == StRun) && enable_i;
  assign fifo_nempty = (cnt_q != '0);
  assign pop         = fifo_nempty && trc_ready_i;

  // Build a candidate trace entry for every port from the raw commit data.
  always_comb begin
    unused_rvfi = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      ent[i].pc    = 64'($signed(rvfi_i[i].pc_rdata));
      ent[i].insn  = rvfi_i[i].insn;
      ent[i].rd    = rvfi_i[i].rd_addr;
      ent[i].wdata = rvfi_i[i].rd_wdata;
      ent[i].fp    = is_fp(rvfi_i[i].insn);
      ent[i].mode  = rvfi_i[i].mode;
      ent[i].trap  = rvfi_i[i].trap & ~rvfi_i[i].valid;
      ent[i].port  = PortW'(i);
      ent[i].cycle = cycle_q;
      unused_rvfi  = unused_rvfi ^ (^{rvfi_i[i].order, rvfi_i[i].cause});
    end
  end

  // Select events in port order; ports above a halting port are ignored entirely.
  always_comb begin
    ev         = '0;
    n_ev       = '0;
    n_ret      = '0;
    n_trap     = '0;
    halt_seen  = 1'b0;
    any_commit = 1'b0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      off[i] = n_ev;
      if (capture && !halt_seen) begin
        if (rvfi_i[i].valid || rvfi_i[i].trap) begin
          ev[i] = 1'b1;
          n_ev  = n_ev + EvW'(1);
        end
        if (rvfi_i[i].valid) begin
          n_ret      = n_ret + EvW'(1);
          any_commit = 1'b1;
          if (rvfi_i[i].insn == HALT_INSN) begin
            halt_seen = 1'b1;
          end
        end else if (rvfi_i[i].trap) begin
          n_trap = n_trap + EvW'(1);
        end
      end
    end
  end

  // All-or-nothing admission; a same-cycle pop frees one slot.
  always_comb begin
    free   = CntW'(FIFO_DEPTH) - cnt_q + CntW'(pop);
    accept = (CntW'(n_ev) <= free);
    mem_d  = mem_q;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      if (ev[i] && accept) begin
        mem_d[(wptr_q + PtrW'(off[i])) & PtrMask] = ent[i];
      end
    end
    wptr_d = accept ? ((wptr_q + PtrW'(n_ev)) & PtrMask) : wptr_q;
    rptr_d = pop ? ((rptr_q + PtrW'(1)) & PtrMask) : rptr_q;
    cnt_d  = cnt_q + (accept ? CntW'(n_ev) : CntW'(0)) - CntW'(pop);
  end

  // Statistics and free-running timestamp.
  always_comb begin
    cycle_d   = cycle_q + CYCLE_W'(1);
    retired_d = retired_q + 64'(n_ret);
    trap_d    = sat_add(trap_q, n_trap);
    drop_d    = accept ? drop_q : sat_add(drop_q, n_ev);
  end

  // RUN/DRAIN/DONE control with commit-stall watchdog; halt takes priority over timeout.
  always_comb begin
    state_d  = state_q;
    wd_d     = wd_q;
    halted_d = halted_q;
    halt_d   = halt_q;
    wdog_d   = wdog_q;
    wd_inc   = wd_q + 32'd1;
    unique case (state_q)
      StRun: begin
        if (enable_i) begin
          wd_d = any_commit ? 32'd0 : wd_inc;
        end
        if (halt_seen) begin
          halted_d = 1'b1;
          state_d  = StDrain;
        end else if ((WATCHDOG_CYCLES != 0) && enable_i && !any_commit &&
                     (wd_inc == 32'(WATCHDOG_CYCLES))) begin
          wdog_d  = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (cnt_d == '0) begin
          halt_d  = halted_q;
          state_d = StDone;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // Control, pointer and statistics registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
      trap_q    <= '0;
      drop_q    <= '0;
      wd_q      <= '0;
      halted_q  <= 1'b0;
      halt_q    <= 1'b0;
      wdog_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
      drop_q    <= drop_d;
      wd_q      <= wd_d;
      halted_q  <= halted_d;
      halt_q    <= halt_d;
      wdog_q    <= wdog_d;
    end
  end

  // Entry storage; contents are qualified by the occupancy count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head = mem_q[rptr_q];

  // Head fields are forced to zero while empty so reset leaves every output at 0.
  always_comb begin
    trc_valid_o    = fifo_nempty;
    trc_pc_o       = '0;
    trc_insn_o     = '0;
    trc_rd_o       = '0;
    trc_rd_wdata_o = '0;
    trc_fp_o       = 1'b0;
    trc_mode_o     = '0;
    trc_trap_o     = 1'b0;
    trc_port_o     = '0;
    trc_cycle_o    = '0;
    if (fifo_nempty) begin
      trc_pc_o       = head.pc;
      trc_insn_o     = head.insn;
      trc_rd_o       = head.rd;
      trc_rd_wdata_o = head.wdata;
      trc_fp_o       = head.fp;
      trc_mode_o     = head.mode;
      trc_trap_o     = head.trap;
      trc_port_o     = head.port;
      trc_cycle_o    = head.cycle;
    end
  end

  assign retired_cnt_o = retired_q;
  assign trap_cnt_o    = trap_q;
  assign drop_cnt_o    = drop_q;
  assign halt_o        = halt_q;
  assign watchdog_o    = wdog_q;

endmodule

// File: doc/rvfi_trace_serializer.md
Name: rvfi_trace_serializer

Overview:
- Synthesisable successor to the simulation-only RVFI tracer.
- Watches all NR_COMMIT_PORTS RVFI commit ports and serialises each cycle's commit and trap events, in port order, into a single valid/ready trace stream through a FIFO.
- Keeps retire, trap and drop statistics, and detects the halt instruction and commit-stall timeouts in hardware.
- Sits beside the core next to the commit stage and feeds an on-chip trace sink or a debug DMA.

Parameters:
- NR_COMMIT_PORTS, 2, number of RVFI commit ports, 1..4.
- FIFO_DEPTH, 8, number of trace entries; must be a power of 2 and at least NR_COMMIT_PORTS.
- CYCLE_W, 32, width of the cycle counter and the timestamp.
- WATCHDOG_CYCLES, 100000, cycles without a valid commit before a timeout is flagged; 0 disables the watchdog.
- HALT_INSN, 32'h00000073, instruction encoding that ends the trace.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- enable_i, in, 1, capture enable.
- rvfi_i, in, rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0], commit ports.
- trc_valid_o, out, 1, head entry valid.
- trc_ready_i, in, 1, sink accepts the head entry.
- trc_pc_o, out, 64, PC sign-extended from riscv::VLEN.
- trc_insn_o, out, 32, instruction.
- trc_rd_o, out, 5, destination register.
- trc_rd_wdata_o, out, riscv::XLEN, write data.
- trc_fp_o, out, 1, destination is an FP register.
- trc_mode_o, out, 2, privilege mode.
- trc_trap_o, out, 1, entry is an exception.
- trc_port_o, out, max(1,$clog2(NR_COMMIT_PORTS)), source port.
- trc_cycle_o, out, CYCLE_W, capture timestamp.
- retired_cnt_o, out, 64, valid commits seen; wraps.
- trap_cnt_o, out, 32, traps seen; saturates.
- drop_cnt_o, out, 32, events dropped; saturates.
- halt_o, out, 1, halt reached and FIFO drained; sticky.
- watchdog_o, out, 1, timeout occurred; sticky.

Behaviour:
- Reset: rst_i high asynchronously empties the FIFO and clears every counter and flag. The state goes to RUN and all outputs read 0. Asserting reset mid-stream discards all entries, and trc_valid_o drops immediately.
- Cycle counter: free-running from reset, wraps at 2^CYCLE_W. The timestamp is the counter value in the capture cycle.
- Event definition: port i has an event when valid=1, or when trap=1 with valid=0. trc_trap_o = trap & ~valid.
- FP decode, opcode check: trc_fp_o=1 when insn[6:0] is 1001111, 1001011, 1000111, 1000011 or 0000111.
- FP decode, OP-FP check: trc_fp_o=1 when insn[6:0]=1010011 and insn[31:26] is none of 111000, 101000, 110000.
- FP decode, compressed check: trc_fp_o=1 when insn[0]=0 and insn[15:13] is 001 (XLEN=64) or 011 (XLEN=32).
- Capture: only in state RUN with enable_i=1. Events are pushed in ascending port index, all in the same cycle.
- Admission is all-or-nothing per cycle:
  - free = FIFO_DEPTH − occupancy + (pop this cycle ? 1 : 0).
  - If the event count exceeds free, no event from that cycle is pushed, and drop_cnt_o increases by the event count.
  - Push and pop in the same cycle are legal.
- Statistics: retired_cnt_o and trap_cnt_o count every observed event while capturing, whether it is admitted or dropped. They hold when enable_i=0 or the state is not RUN.
- Output handshake:
  - trc_valid_o = FIFO non-empty.
  - Head fields are registered and stay stable while valid & ~ready.
  - A pop happens on valid & ready.
  - Minimum latency from capture to trc_valid_o is 1 cycle.
- State machine RUN: a valid commit with insn==HALT_INSN on port h moves the state to DRAIN. Events on ports ≤h that cycle are processed normally. Events on ports >h are ignored and not counted as drops.
- State machine RUN: the watchdog counter clears on any valid commit, otherwise increments while enable_i=1. When it reaches WATCHDOG_CYCLES (nonzero), watchdog_o is set and the state moves to DRAIN. If halt and timeout occur in the same cycle, halt wins.
- State machine DRAIN: no capture. When the FIFO is empty the state moves to DONE.
- State machine DONE: halt_o is set only if DRAIN was entered through halt. The state stays in DONE until reset.
- Counter limits: drop and trap counters saturate at 0xFFFFFFFF. retired_cnt_o wraps modulo 2^64.

Test Plan:
- Single commit: port0 valid, pc 0x80000000, insn 0x00500093, rd 1, wdata 5, trc_ready_i=1 → next cycle one entry with trc_rd_o=1, trc_fp_o=0, trc_port_o=0, trc_cycle_o equal to the capture cycle, retired_cnt_o=1.
- Dual commit: ports 0 and 1 valid in one cycle, ready=1 → two consecutive entries, port0 first then port1, same timestamp. An fld insn 0x00053087 yields trc_fp_o=1.
- Backpressure: FIFO_DEPTH=8, ready=0, 5 cycles of dual commits.
  - The first 4 cycles fill the FIFO (8 entries); the 5th cycle drops both events.
  - Expect drop_cnt_o=2 and retired_cnt_o=10. Head fields stay stable while ready=0.
- Halt: port0 commits 0x00000073 while port1 commits another instruction, with 3 entries queued → the port1 event is ignored (drop_cnt_o unchanged). After 4 pops halt_o=1; later commits change nothing.
- Watchdog: WATCHDOG_CYCLES=16, a trap-only event every cycle and no valid commit → watchdog_o=1 after 16 cycles, trap_cnt_o=16, halt_o stays 0.
- Reset mid-stream: 6 entries queued, rst_i pulsed → outputs immediately 0. After release, capture resumes with trc_cycle_o starting from 0.
